// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans a SRC_W x SRC_H frame buffer into a scaled (x1/x2/x4), offset
// window of the VGA display, with border colour outside the window and a RAM_LAT-aware output pipeline.
module vga_frame_reader #(
    parameter int              AW      = 15,
    parameter int              DW      = 12,
    parameter int              SRC_W   = 160,
    parameter int              SRC_H   = 120,
    parameter int              DISP_W  = 640,
    parameter int              DISP_H  = 480,
    parameter int              RAM_LAT = 1,
    parameter logic [DW-1:0]   BORDER  = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    vga_posX,
    input  logic [9:0]    vga_posY,
    input  logic [1:0]    scale_sel,
    input  logic [9:0]    off_x,
    input  logic [9:0]    off_y,
    input  logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] pixel_out,
    output logic          in_window,
    output logic          frame_done
);
    localparam int            CW        = $clog2(SRC_W);
    localparam logic [AW-1:0] BLACK     = AW'(SRC_W * SRC_H);
    localparam logic [AW-1:0] LAST_ROW  = AW'((SRC_H - 1) * SRC_W);
    localparam logic [AW-1:0] ROW_STEP  = AW'(SRC_W);
    localparam logic [CW-1:0] LAST_COL  = CW'(SRC_W - 1);
    localparam logic [9:0]    XW        = 10'(DISP_W);
    localparam logic [9:0]    YH        = 10'(DISP_H);
    localparam logic [9:0]    XMAX      = 10'(DISP_W - 1);
    localparam logic [9:0]    YMAX      = 10'(DISP_H - 1);

    typedef enum logic [2:0] {IDLE, VPRE, LINE_WAIT, ACTIVE, LINE_DONE, VPOST} state_t;

    state_t          r_state, w_st, w_nstate;
    logic [1:0]      r_smax, r_subx, r_suby;
    logic [9:0]      r_offx, r_offy, r_prev_y;
    logic [CW-1:0]   r_col;
    logic [AW-1:0]   r_row, r_addr;
    logic            r_more, r_prev_zero, r_fd, r_inwin;
    logic [RAM_LAT:0] r_win;
    logic [DW-1:0]   r_pix;

    logic            w_fs, w_more, w_done, w_pix, w_end, w_lastr, w_xwrap, w_ywrap, w_adv, w_nmore;
    logic [1:0]      w_smax, w_subx, w_suby, w_nsubx, w_nsuby;
    logic [9:0]      w_offx, w_offy;
    logic [CW-1:0]   w_col, w_ncol;
    logic [AW-1:0]   w_row, w_nrow, w_addr;

    // The current position is resolved through every transition it can trigger this cycle,
    // so a window starting at X=0 or a line starting at posY change gets its pixel on time.
    always_comb begin
        w_fs    = (vga_posX == '0) && (vga_posY == '0) && !r_prev_zero;
        w_smax  = w_fs ? ((scale_sel == 2'd0) ? 2'd0 : (scale_sel == 2'd1) ? 2'd1 : 2'd3) : r_smax;
        w_offx  = w_fs ? off_x : r_offx;
        w_offy  = w_fs ? off_y : r_offy;
        w_col   = w_fs ? '0 : r_col;
        w_subx  = w_fs ? '0 : r_subx;
        w_suby  = w_fs ? '0 : r_suby;
        w_row   = w_fs ? '0 : r_row;
        w_more  = w_fs ? 1'b0 : r_more;
        w_st    = w_fs ? VPRE : r_state;
        w_done  = 1'b0;
        if (w_st == VPRE && w_offx < XW && w_offy < YH && vga_posY == w_offy)
            w_st = LINE_WAIT;
        if (w_st == LINE_DONE && vga_posY != r_prev_y) begin
            w_done = !w_more;
            w_st   = w_more ? LINE_WAIT : VPOST;
        end
        w_pix    = (w_st == ACTIVE) || (w_st == LINE_WAIT && vga_posX == w_offx);
        w_xwrap  = w_subx == w_smax;
        w_ywrap  = w_suby == w_smax;
        w_end    = w_pix && ((w_col == LAST_COL && w_xwrap) || vga_posX == XMAX);
        w_lastr  = (w_row == LAST_ROW && w_ywrap) || vga_posY == YMAX;
        w_adv    = w_end && !w_lastr;
        w_nstate = w_pix ? (w_end ? LINE_DONE : ACTIVE) : w_st;
        w_nsubx  = (!w_pix || w_end || w_xwrap) ? '0 : w_subx + 2'd1;
        w_ncol   = (!w_pix || w_end) ? '0 : w_col + CW'(w_xwrap);
        w_nsuby  = w_adv ? (w_ywrap ? '0 : w_suby + 2'd1) : w_suby;
        w_nrow   = (w_adv && w_ywrap) ? w_row + ROW_STEP : w_row;
        w_nmore  = w_end ? !w_lastr : w_more;
        w_addr   = w_pix ? w_row + AW'(w_col) : BLACK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_nstate;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smax      <= '0;
            r_offx      <= '0;
            r_offy      <= '0;
            r_col       <= '0;
            r_subx      <= '0;
            r_suby      <= '0;
            r_row       <= '0;
            r_more      <= 1'b0;
            r_prev_zero <= 1'b1;
            r_prev_y    <= '0;
            r_addr      <= BLACK;
            r_fd        <= 1'b0;
            r_win       <= '0;
            r_inwin     <= 1'b0;
            r_pix       <= BORDER;
        end else begin
            r_smax      <= w_smax;
            r_offx      <= w_offx;
            r_offy      <= w_offy;
            r_col       <= w_ncol;
            r_subx      <= w_nsubx;
            r_suby      <= w_nsuby;
            r_row       <= w_nrow;
            r_more      <= w_nmore;
            r_prev_zero <= (vga_posX == '0) && (vga_posY == '0);
            r_prev_y    <= vga_posY;
            r_addr      <= w_addr;
            r_fd        <= w_done;
            r_win       <= {r_win[RAM_LAT-1:0], w_pix};
            r_inwin     <= r_win[RAM_LAT];
            r_pix       <= r_win[RAM_LAT] ? ram_data : BORDER;
        end
    end

    assign ram_addr   = r_addr;
    assign pixel_out  = r_pix;
    assign in_window  = r_inwin;
    assign frame_done = r_fd;
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: scans reduced-size frames with directed and random window settings,
// comparing every output against a window/address model built from plain arithmetic.
module tb_vga_frame_reader;
    localparam int AW = 8, DW = 12, SW = 16, SH = 12, DWD = 64, DHD = 48, HT = 72, VT = 50;
    localparam logic [DW-1:0] BORDER = 12'h5A3;
    localparam int NF = 16;

    logic          clk, rst;
    logic [9:0]    vga_posX, vga_posY, off_x, off_y;
    logic [1:0]    scale_sel;
    logic [DW-1:0] ram_data, pixel_out;
    logic [AW-1:0] ram_addr;
    logic          in_window, frame_done;

    vga_frame_reader #(.AW(AW), .DW(DW), .SRC_W(SW), .SRC_H(SH), .DISP_W(DWD), .DISP_H(DHD),
                       .RAM_LAT(1), .BORDER(BORDER)) dut (
        .clk(clk), .rst(rst), .vga_posX(vga_posX), .vga_posY(vga_posY), .scale_sel(scale_sel),
        .off_x(off_x), .off_y(off_y), .ram_data(ram_data), .ram_addr(ram_addr),
        .pixel_out(pixel_out), .in_window(in_window), .frame_done(frame_done));

    logic [DW-1:0] mem [0:255];
    always @(posedge clk) ram_data <= mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int m_act = 0, m_pz = 1, m_s = 1, m_ox = 0, m_oy = 0;
    logic [2:0]    h_w = '0;
    logic [DW-1:0] h_p [3] = '{BORDER, BORDER, BORDER};
    int f_sel [NF], f_ox [NF], f_oy [NF];
    int cur_sel, cur_ox, cur_oy;

    task automatic chk(input string tag, input int x, input int y, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s at (%0d,%0d): got %0h expected %0h", tag, x, y, got, exp);
        end
    endtask

    task automatic tick(input int x, input int y);
        int ylim;
        logic ew, ef;
        logic [AW-1:0] ea;
        vga_posX = 10'(x); vga_posY = 10'(y);
        scale_sel = 2'(cur_sel); off_x = 10'(cur_ox); off_y = 10'(cur_oy);
        if (rst) begin
            if (m_pz == 0 && x == 0 && y == 0) begin
                m_act = 1;
                m_s   = (cur_sel == 0) ? 1 : (cur_sel == 1) ? 2 : 4;
                m_ox  = cur_ox;
                m_oy  = cur_oy;
            end
            m_pz = (x == 0 && y == 0) ? 1 : 0;
        end
        ylim = (m_oy + SH * m_s < DHD) ? m_oy + SH * m_s : DHD;
        ew = m_act != 0 && m_ox < DWD && m_oy < DHD && x >= m_ox && x < m_ox + SW * m_s && x < DWD
             && y >= m_oy && y < ylim;
        ea = ew ? AW'(((y - m_oy) / m_s) * SW + (x - m_ox) / m_s) : AW'(SW * SH);
        ef = m_act != 0 && m_ox < DWD && m_oy < DHD && x == 0 && y == ylim;
        h_w = {h_w[1:0], ew};
        h_p[2] = h_p[1]; h_p[1] = h_p[0]; h_p[0] = ew ? mem[ea] : BORDER;
        @(posedge clk); #1;
        chk("ram_addr", x, y, 32'(ram_addr), 32'(ea));
        chk("frame_done", x, y, 32'(frame_done), 32'(ef));
        chk("in_window", x, y, 32'(in_window), 32'(h_w[2]));
        chk("pixel_out", x, y, 32'(pixel_out), 32'(h_p[2]));
    endtask

    task automatic chk_reset(input int x, input int y);
        chk("rst_addr", x, y, 32'(ram_addr), 32'(SW * SH));
        chk("rst_pixel", x, y, 32'(pixel_out), 32'(BORDER));
        chk("rst_win", x, y, 32'(in_window), 32'd0);
        chk("rst_done", x, y, 32'(frame_done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        f_sel = '{0, 3, 1, 2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        f_ox  = '{0, 0, 10, 32, 3, 3, 64, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        f_oy  = '{0, 0, 5, 0, 2, 2, 0, 48, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 10; i < NF; i++) begin
            f_sel[i] = int'($urandom_range(0, 3));
            f_ox[i]  = int'($urandom_range(0, 70));
            f_oy[i]  = int'($urandom_range(0, 49));
        end
        rst = 1'b0;
        cur_sel = 0; cur_ox = 0; cur_oy = 0;
        vga_posX = 10'(HT - 1); vga_posY = 10'(VT - 1);
        scale_sel = '0; off_x = '0; off_y = '0;
        @(posedge clk); #1;
        chk_reset(HT - 1, VT - 1);
        rst = 1'b1;
        tick(HT - 1, VT - 1);
        for (int f = 0; f < NF; f++) begin
            for (int y = 0; y < VT; y++) begin
                for (int x = 0; x < HT; x++) begin
                    if (x == 0 && y == 0) begin
                        cur_sel = f_sel[f]; cur_ox = f_ox[f]; cur_oy = f_oy[f];
                    end else if (x == 0) begin
                        cur_sel = int'($urandom_range(0, 3));
                        cur_ox  = int'($urandom_range(0, 1023));
                        cur_oy  = int'($urandom_range(0, 1023));
                    end
                    if (f == 8 && y == 6 && x == 10) begin
                        rst = 1'b0;
                        m_act = 0; m_pz = 1; h_w = '0;
                        h_p = '{BORDER, BORDER, BORDER};
                        #1;
                        chk_reset(x, y);
                    end
                    if (f == 8 && y == 6 && x == 14) rst = 1'b1;
                    tick(x, y);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
